draw_rect: RTL and testbench

Parametrised rectangle rasteriser. It replaces the fixed full-screen background fill with a general fill or outline of any rectangle. On `start` it latches the rectangle, clips it to the screen, and walks the pixels in raster order. For each pixel it dispatches one plot instruction to the shared datapath over the `start_dp`/`finished_dp` handshake. It sits between the game/UI sequencer and the datapath arbiter and is used for background clears, sprite boxes and UI frames.

---
 rtl/draw_rect.sv | 204 ++++++++++++++++++++
 tb/tb_draw_rect.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/draw_rect.sv
// +----------------------------------------------------------------------------+
// | draw_rect: clipped rectangle fill/outline rasteriser, one plot per pixel.   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module draw_rect #(
  parameter int          X_W      = 8,
  parameter int          Y_W      = 7,
  parameter int          COLOUR_W = 3,
  parameter int          SCREEN_W = 160,
  parameter int          SCREEN_H = 120,
  parameter logic [3:0]  OPCODE   = 4'd1,
  parameter int          INSTR_W  = 32,
  parameter int          RESULT_W = 32
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 start,
  input  logic [X_W-1:0]       x0,
  input  logic [Y_W-1:0]       y0,
  input  logic [X_W-1:0]       width,
  input  logic [Y_W-1:0]       height,
  input  logic [COLOUR_W-1:0]  colour_in,
  input  logic                 outline,
  output logic                 finished,
  output logic [X_W+Y_W-1:0]   pixel_count,
  input  logic                 finished_dp,
  input  logic [RESULT_W-1:0]  result_dp,
  output logic                 start_dp,
  output logic [INSTR_W-1:0]   instruction_dp
);

  localparam int         CNT_W    = X_W + Y_W;
  localparam int         PLOT_BIT = COLOUR_W + Y_W + X_W;
  localparam logic [X_W:0] X_LAST = (X_W+1)'(SCREEN_W - 1);
  localparam logic [X_W:0] X_SCR  = (X_W+1)'(SCREEN_W);
  localparam logic [Y_W:0] Y_LAST = (Y_W+1)'(SCREEN_H - 1);
  localparam logic [Y_W:0] Y_SCR  = (Y_W+1)'(SCREEN_H);

  typedef enum logic [2:0] {
    STANDBY    = 3'd0,
    SETUP      = 3'd1,
    DRAW_START = 3'd2,
    DRAW_DELAY = 3'd3,
    DRAW_WAIT  = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [X_W-1:0]       x0_q, x0_d;
  logic [Y_W-1:0]       y0_q, y0_d;
  logic [X_W-1:0]       w_q, w_d;
  logic [Y_W-1:0]       h_q, h_d;
  logic [COLOUR_W-1:0]  colour_q, colour_d;
  logic                 outline_q, outline_d;
  logic [X_W-1:0]       xe_q, xe_d;
  logic [Y_W-1:0]       ye_q, ye_d;
  logic [X_W-1:0]       x_q, x_d;
  logic [Y_W-1:0]       y_q, y_d;
  logic [CNT_W-1:0]     count_q, count_d;

  // Bounds are formed one bit wider so x0+width-1 cannot wrap before clipping.
  logic [X_W:0] xe_sum, xe_clip;
  logic [Y_W:0] ye_sum, ye_clip;
  logic         rect_empty;

  always_comb begin
    xe_sum     = {1'b0, x0_q} + {1'b0, w_q} - (X_W+1)'(1);
    ye_sum     = {1'b0, y0_q} + {1'b0, h_q} - (Y_W+1)'(1);
    xe_clip    = (xe_sum > X_LAST) ? X_LAST : xe_sum;
    ye_clip    = (ye_sum > Y_LAST) ? Y_LAST : ye_sum;
    rect_empty = (w_q == '0) || (h_q == '0) ||
                 ({1'b0, x0_q} >= X_SCR) || ({1'b0, y0_q} >= Y_SCR);
  end

  logic last_col, last_row, edge_row;

  always_comb begin
    last_col = (x_q == xe_q);
    last_row = (y_q == ye_q);
    edge_row = (y_q == y0_q) || last_row;
  end

  always_comb begin
    state_d   = state_q;
    x0_d      = x0_q;
    y0_d      = y0_q;
    w_d       = w_q;
    h_d       = h_q;
    colour_d  = colour_q;
    outline_d = outline_q;
    xe_d      = xe_q;
    ye_d      = ye_q;
    x_d       = x_q;
    y_d       = y_q;
    count_d   = count_q;

    unique case (state_q)
      STANDBY: begin
        if (start) begin
          x0_d      = x0;
          y0_d      = y0;
          w_d       = width;
          h_d       = height;
          colour_d  = colour_in;
          outline_d = outline;
          count_d   = '0;
          state_d   = SETUP;
        end
      end

      SETUP: begin
        xe_d = xe_clip[X_W-1:0];
        ye_d = ye_clip[Y_W-1:0];
        x_d  = x0_q;
        y_d  = y0_q;
        if (rect_empty) begin
          state_d = STANDBY;
        end else begin
          state_d = DRAW_START;
        end
      end

      DRAW_START: state_d = DRAW_DELAY;

      DRAW_DELAY: state_d = DRAW_WAIT;

      DRAW_WAIT: begin
        if (finished_dp) begin
          count_d = count_q + CNT_W'(1);
          state_d = DRAW_START;
          // Interior outline rows only ever sit at x0 or xe, so a
          // non-final column there means "jump to the right edge".
          if (!last_col) begin
            x_d = (outline_q && !edge_row) ? xe_q : x_q + X_W'(1);
          end else if (last_row) begin
            state_d = STANDBY;
          end else begin
            x_d = x0_q;
            y_d = y_q + Y_W'(1);
          end
        end
      end

      default: state_d = STANDBY;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q   <= STANDBY;
      x0_q      <= '0;
      y0_q      <= '0;
      w_q       <= '0;
      h_q       <= '0;
      colour_q  <= '0;
      outline_q <= 1'b0;
      xe_q      <= '0;
      ye_q      <= '0;
      x_q       <= '0;
      y_q       <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      x0_q      <= x0_d;
      y0_q      <= y0_d;
      w_q       <= w_d;
      h_q       <= h_d;
      colour_q  <= colour_d;
      outline_q <= outline_d;
      xe_q      <= xe_d;
      ye_q      <= ye_d;
      x_q       <= x_d;
      y_q       <= y_d;
      count_q   <= count_d;
    end
  end

  logic drawing;

  always_comb begin
    drawing        = (state_q == DRAW_START) || (state_q == DRAW_DELAY) ||
                     (state_q == DRAW_WAIT);
    instruction_dp = '0;
    if (drawing) begin
      instruction_dp[INSTR_W-1 -: 4]        = OPCODE;
      instruction_dp[PLOT_BIT]              = 1'b1;
      instruction_dp[PLOT_BIT-1 -: COLOUR_W] = colour_q;
      instruction_dp[X_W+Y_W-1 -: Y_W]      = y_q;
      instruction_dp[X_W-1:0]               = x_q;
    end
  end

  assign finished    = (state_q == STANDBY);
  assign start_dp    = (state_q == DRAW_START) || (state_q == DRAW_DELAY);
  assign pixel_count = count_q;

  // The plot datapath returns nothing this block needs.
  logic result_unused;
  assign result_unused = ^result_dp;

endmodule

`default_nettype wire

// File: tb/tb_draw_rect.sv
// +----------------------------------------------------------------------------+
// | tb_draw_rect: directed self-checking bench for draw_rect (X_W=9 build).    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_draw_rect;

  localparam int X_W = 9;
  localparam int Y_W = 7;

  logic              clock = 1'b0;
  logic              resetn;
  logic              start;
  logic [X_W-1:0]    x0;
  logic [Y_W-1:0]    y0;
  logic [X_W-1:0]    width;
  logic [Y_W-1:0]    height;
  logic [2:0]        colour_in;
  logic              outline;
  logic              finished;
  logic [X_W+Y_W-1:0] pixel_count;
  logic              finished_dp;
  logic [31:0]       result_dp;
  logic              start_dp;
  logic [31:0]       instruction_dp;

  draw_rect #(.X_W(X_W)) dut (
    .clock          (clock),
    .resetn         (resetn),
    .start          (start),
    .x0             (x0),
    .y0             (y0),
    .width          (width),
    .height         (height),
    .colour_in      (colour_in),
    .outline        (outline),
    .finished       (finished),
    .pixel_count    (pixel_count),
    .finished_dp    (finished_dp),
    .result_dp      (result_dp),
    .start_dp       (start_dp),
    .instruction_dp (instruction_dp)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  always @(posedge clock) cyc++;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Plot word: {opcode 4'd1, 8 zero bits, plot bit, colour[2:0], y[6:0], x[8:0]}
  function automatic logic [31:0] make_word(input int x, input int y, input int col);
    logic [31:0] w;
    w        = '0;
    w[31:28] = 4'd1;
    w[19]    = 1'b1;
    w[18:16] = col[2:0];
    w[15:9]  = y[6:0];
    w[8:0]   = x[8:0];
    return w;
  endfunction

  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];

  function automatic void build_exp(input int x, input int y, input int w, input int h,
                                    input int col, input bit outl);
    int xe, ye;
    exp_q.delete();
    if (w == 0 || h == 0 || x >= 160 || y >= 120) return;
    xe = (x + w - 1 > 159) ? 159 : x + w - 1;
    ye = (y + h - 1 > 119) ? 119 : y + h - 1;
    for (int yy = y; yy <= ye; yy++)
      for (int xx = x; xx <= xe; xx++)
        if (!outl || yy == y || yy == ye || xx == x || xx == xe)
          exp_q.push_back(make_word(xx, yy, col));
  endfunction

  // Datapath model: records each dispatch and answers after dp_delay WAIT cycles.
  int          dp_delay = 0;
  int          wcnt = 0;
  int          sdp_first = -1;
  bit          in_wait = 1'b0;
  bit          prev_sdp = 1'b0;
  logic [31:0] cur_word = '0;

  always @(negedge clock) begin
    if (!resetn) begin
      in_wait     = 1'b0;
      finished_dp = 1'b0;
    end else begin
      if (start_dp && !prev_sdp) begin
        cur_word = instruction_dp;
        got_q.push_back(instruction_dp);
        if (sdp_first < 0) sdp_first = cyc;
      end else if (start_dp) begin
        chk("hold_delay", instruction_dp, cur_word);
      end
      if (!start_dp && prev_sdp && !finished) begin
        in_wait = 1'b1;
        wcnt    = 0;
      end
      if (in_wait) begin
        chk("hold_wait", instruction_dp, cur_word);
        if (wcnt == dp_delay) begin
          finished_dp = 1'b1;
          in_wait     = 1'b0;
        end else begin
          wcnt++;
        end
      end else begin
        finished_dp = 1'b0;
      end
    end
    prev_sdp = start_dp;
  end

  task automatic run_rect(input string tag, input int x, input int y, input int w,
                          input int h, input int col, input bit outl,
                          input int delay, input bit busy);
    int s_cyc, fin_cyc, n, ne;
    build_exp(x, y, w, h, col, outl);
    got_q.delete();
    sdp_first = -1;
    dp_delay  = delay;
    @(posedge clock); #1;
    x0 = x[X_W-1:0]; y0 = y[Y_W-1:0]; width = w[X_W-1:0]; height = h[Y_W-1:0];
    colour_in = col[2:0]; outline = outl; start = 1'b1;
    s_cyc = cyc;
    @(posedge clock); #1;
    start = 1'b0;
    x0 = 9'd77; y0 = 7'd33; width = 9'd9; height = 7'd9; colour_in = 3'd2; outline = ~outl;
    @(negedge clock);
    chk({tag, "_busy"}, finished, 1'b0);
    n = 0;
    while (!finished && n < 3000) begin
      @(negedge clock);
      n++;
      if (busy && cyc == s_cyc + 4) begin
        start = 1'b1; x0 = 9'd50; width = 9'd1;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    fin_cyc = cyc;
    chk({tag, "_done"}, finished, 1'b1);
    ne = exp_q.size();
    chk({tag, "_ndisp"}, got_q.size(), ne);
    for (int i = 0; i < ne && i < got_q.size(); i++)
      chk({tag, "_word"}, got_q[i], exp_q[i]);
    chk({tag, "_pcount"}, pixel_count, ne);
    if (ne == 0) begin
      chk({tag, "_fin_lat"}, fin_cyc - s_cyc, 2);
    end else begin
      chk({tag, "_sdp_lat"}, sdp_first - s_cyc, 2);
      chk({tag, "_fin_lat"}, fin_cyc - sdp_first, ne * (3 + delay));
    end
  endtask

  initial begin
    int nd;
    resetn = 1'b0; start = 1'b0; x0 = '0; y0 = '0; width = '0; height = '0;
    colour_in = '0; outline = 1'b0; finished_dp = 1'b0; result_dp = 32'hDEAD_BEEF;

    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_finished", finished, 1'b1);
    chk("rst_start_dp", start_dp, 1'b0);
    chk("rst_instr", instruction_dp, 32'h0);
    chk("rst_pcount", pixel_count, 16'h0);
    @(posedge clock); #1;
    resetn = 1'b1;

    run_rect("fill", 3, 5, 2, 2, 5, 1'b0, 0, 1'b0);
    chk("fill_w0_literal", got_q.size() > 0 ? got_q[0] : 32'h0, 32'h100D_0A03);
    run_rect("outline", 0, 0, 4, 3, 6, 1'b1, 0, 1'b0);
    run_rect("outline_1wide", 10, 20, 1, 4, 3, 1'b1, 0, 1'b0);
    run_rect("outline_1high", 30, 40, 5, 1, 1, 1'b1, 0, 1'b0);
    run_rect("clip", 158, 118, 5, 5, 7, 1'b0, 0, 1'b0);
    run_rect("clip_outline", 156, 117, 10, 10, 4, 1'b1, 1, 1'b0);
    run_rect("empty_w0", 3, 5, 0, 2, 5, 1'b0, 0, 1'b0);
    run_rect("empty_x200", 200, 5, 3, 2, 5, 1'b0, 0, 1'b0);
    run_rect("empty_h0", 3, 5, 2, 0, 5, 1'b1, 0, 1'b0);
    run_rect("busy_start", 10, 10, 3, 2, 2, 1'b0, 2, 1'b1);
    run_rect("stall", 3, 5, 2, 2, 5, 1'b0, 7, 1'b0);

    // Reset while the first pixel is in DRAW_DELAY.
    got_q.delete();
    dp_delay = 0;
    @(posedge clock); #1;
    x0 = 9'd20; y0 = 7'd20; width = 9'd4; height = 7'd4; colour_in = 3'd1;
    outline = 1'b0; start = 1'b1;
    @(posedge clock); #1; start = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    chk("rstmid_in_delay", start_dp, 1'b1);
    resetn = 1'b0;
    @(posedge clock); #1;
    chk("rstmid_start_dp", start_dp, 1'b0);
    chk("rstmid_finished", finished, 1'b1);
    chk("rstmid_instr", instruction_dp, 32'h0);
    chk("rstmid_pcount", pixel_count, 16'h0);
    resetn = 1'b1;
    nd = got_q.size();
    repeat (10) @(posedge clock);
    #1;
    chk("rstmid_no_dispatch", got_q.size(), nd);
    chk("rstmid_idle", finished, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
